// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response channel, redirect
// from the core, and the instruction handshake toward the core's cmd input.
interface ifu_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, small instruction FIFO,
// redirect flush. Define IFU_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic       clk,
    input  logic       rst,
    ifu_fetch_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          req_valid_q, req_valid_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic        flush;
    logic        req_fire;
    logic        resp_take;
    logic        fifo_empty;
    logic        bypass;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsb;

    assign redirect_target     = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    assign flush      = bus.redirect_valid && (state_q != IDLE);
    assign req_fire   = req_valid_q && bus.imem_req_ready;
    assign resp_take  = (state_q == WAIT) && bus.imem_resp_valid && !flush;
    assign fifo_empty = (count_q == '0);

`ifdef IFU_BYPASS_EN
    assign bypass = fifo_empty && resp_take;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that the core takes immediately never occupies a slot.
    assign wr_en = resp_take && !(bypass && bus.inst_ready);
    assign rd_en = !fifo_empty && bus.inst_ready && !flush;

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;

    always_comb begin
        bus.inst_valid = !fifo_empty || bypass;
        bus.inst       = '0;
        bus.inst_pc    = '0;
        if (!fifo_empty) begin
            bus.inst    = fifo_inst_q[rd_ptr_q];
            bus.inst_pc = fifo_pc_q[rd_ptr_q];
        end else if (bypass) begin
            bus.inst    = bus.imem_resp_data;
            bus.inst_pc = req_pc_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (req_fire) begin
                    state_d  = WAIT;
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                end
            end
            WAIT, DROP: begin
                if (bus.imem_resp_valid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        // Redirect overrides everything; an accepted-but-unanswered request
        // still has a response coming, which DROP swallows.
        if (flush) begin
            pc_d = redirect_target;
            if (state_q == FETCH) begin
                state_d = req_fire ? DROP : FETCH;
            end else begin
                state_d = bus.imem_resp_valid ? FETCH : DROP;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // Only request when the response is guaranteed a FIFO slot.
        req_valid_d = (state_d == FETCH) && (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        if (wr_en) begin
            fifo_inst_q[wr_ptr_q] <= bus.imem_resp_data;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder, directed scenarios, random traffic,
// and a scoreboard of expected PCs derived from reset/redirect targets.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int unsigned DEPTH = 2;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int delivered = 0;
    logic [31:0] exp_q[$];

    // memory model controls: 0 random ready, 1 always ready, 2 never ready
    int mem_rdy_mode = 1;
    int lat_min = 0;
    int lat_max = 0;
    bit mem_busy = 0;
    int mem_wait = 0;
    logic [31:0] mem_addr = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected delivery order: consecutive words from the latest restart point.
    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic set_redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        refill({target[31:2], 2'b00});
    endtask

    task automatic wait_fire(output logic [31:0] a, output bit ok);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                a  = bus.imem_req_addr;
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Scoreboard monitor
    initial begin
        bit prev_redir;
        logic [31:0] e;
        prev_redir = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_redir) check("flush_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
                if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        exp_q.push_back(exp_q[$] + 32'd4);
                        check("inst_pc", bus.inst_pc, e);
                        check("inst_data", bus.inst, memf(e));
                    end
                    delivered++;
                end
            end
            prev_redir = bus.redirect_valid && !rst;
        end
    end

    // Instruction memory: one response per accepted request after lat cycles
    initial begin
        bit stall_prev;
        logic [31:0] stall_addr;
        stall_prev = 1'b0;
        stall_addr = '0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_busy   = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("req_hold_valid", {31'b0, bus.imem_req_valid}, 32'd1);
                    check("req_hold_addr", bus.imem_req_addr, stall_addr);
                end
                stall_prev = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
                stall_addr = bus.imem_req_addr;
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    check("one_outstanding", {31'b0, mem_busy}, 32'd0);
                    check("req_aligned", {30'b0, bus.imem_req_addr[1:0]}, 32'd0);
                    mem_busy = 1'b1;
                    mem_addr = bus.imem_req_addr;
                    mem_wait = $urandom_range(lat_max, lat_min);
                end
            end
            @(posedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
            if (mem_busy) begin
                if (mem_wait == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = memf(mem_addr);
                    mem_busy = 1'b0;
                end else begin
                    mem_wait--;
                end
            end
            case (mem_rdy_mode)
                0:       bus.imem_req_ready = ($urandom_range(0, 3) != 0);
                1:       bus.imem_req_ready = 1'b1;
                default: bus.imem_req_ready = 1'b0;
            endcase
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [31:0] a;
        bit ok;
        bit found;
        int d0;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;
        refill(RESET_PC);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        @(negedge clk);
        check("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("first_req_addr", bus.imem_req_addr, RESET_PC);
        @(negedge clk);
        check("resp_cycle_valid", {31'b0, bus.inst_valid}, {31'b0, BYP});
`ifdef IFU_BYPASS_EN
        check("bypass_inst", bus.inst, memf(RESET_PC));
`endif
        @(negedge clk);
        check("resp_next_valid", {31'b0, bus.inst_valid}, {31'b0, !BYP});

        // steady state with zero-wait memory: one instruction every 2 cycles
        @(posedge clk);
        #1 d0 = delivered;
        repeat (20) @(posedge clk);
        #1 check("throughput", 32'(delivered - d0), 32'd10);

        // FIFO fill with core stalled, then drain
        set_redirect(RESET_PC);
        bus.inst_ready = 1'b0;
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("full_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        check("full_inst_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("full_head_pc", bus.inst_pc, RESET_PC);
        @(posedge clk);
        #1 bus.inst_ready = 1'b1;
        wait_fire(a, ok);
        check("resume_seen", {31'b0, ok}, 32'd1);
        check("resume_addr", a, RESET_PC + 32'd8);

        // memory not ready for 3 cycles
        @(negedge clk);
        mem_rdy_mode = 2;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.imem_req_valid;
        end
        check("stall_req_seen", {31'b0, ok}, 32'd1);
        a = bus.imem_req_addr;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", {31'b0, bus.imem_req_valid}, 32'd1);
            check("stall_addr", bus.imem_req_addr, a);
        end
        mem_rdy_mode = 1;
        begin
            logic [31:0] b;
            wait_fire(b, ok);
            check("stall_accept_seen", {31'b0, ok}, 32'd1);
            check("stall_accept_addr", b, a);
        end

        // redirect while a request is outstanding
        lat_min = 2;
        lat_max = 2;
        wait_fire(a, ok);
        check("wait_req_seen", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1 set_redirect(32'h8000_0103);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        wait_fire(a, ok);
        check("redir_wait_seen", {31'b0, ok}, 32'd1);
        check("redir_wait_addr", a, 32'h8000_0100);
        @(negedge clk);
        lat_min = 0;
        lat_max = 0;

        // redirect in the same cycle as a request handshake and a pop
        @(posedge clk);
        #1 bus.inst_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1 bus.inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.imem_req_valid && bus.inst_valid) begin
                set_redirect(32'h8000_0200);
                found = 1'b1;
            end
        end
        check("hs_pop_found", {31'b0, found}, 32'd1);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        wait_fire(a, ok);
        check("redir_hs_seen", {31'b0, ok}, 32'd1);
        check("redir_hs_addr", a, 32'h8000_0200);

        // PC wraps past the top of the address space
        @(posedge clk);
        #1 set_redirect(32'hFFFF_FFF9);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        repeat (20) @(posedge clk);

        // random traffic
        #1;
        mem_rdy_mode = 0;
        lat_min = 0;
        lat_max = 2;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            if (!bus.redirect_valid && $urandom_range(0, 19) == 0) set_redirect($urandom);
            else bus.redirect_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        mem_rdy_mode = 1;
        repeat (50) @(posedge clk);
        check("random_progress", {31'b0, (delivered - d0) > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
